// File: rtl/cpu_mult_pkg.sv
// Shared definitions for the pipelined multiplier: mode encodings and signedness decode.
package cpu_mult_pkg;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'd0,  // low word
    MODE_MULXUU = 2'd1,  // high word, unsigned x unsigned
    MODE_MULXSU = 2'd2,  // high word, signed src1 x unsigned src2
    MODE_MULXSS = 2'd3   // high word, signed x signed
  } mode_e;

  localparam int STAGES = 3;

  typedef struct packed {
    logic s1;  // src1 treated as signed
    logic s2;  // src2 treated as signed
  } sgn_t;

  // Signedness of each operand for a given mode.
  function automatic sgn_t mode_sign(mode_e m);
    sgn_t s;
    s.s1 = (m == MODE_MULXSU) || (m == MODE_MULXSS);
    s.s2 = (m == MODE_MULXSS);
    return s;
  endfunction

endpackage

// File: rtl/cpu_mult_partial.sv
// One registered unsigned HALF_W x HALF_W multiply; meant to land on a DSP multiplier.
module cpu_mult_partial #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [HALF_W-1:0]     i_a,
  input  logic [HALF_W-1:0]     i_b,
  output logic [2*HALF_W-1:0]   o_p
);

  logic [2*HALF_W-1:0] r_p;

  // Product register; holds while the stage is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_p <= '0;
    else if (en)   r_p <= i_a * i_b;
  end

  assign o_p = r_p;

endmodule

// File: rtl/cpu_mult_pipe.sv
// Three-stage integer multiplier: partials + sign corrections, 2*DATA_W sum, word select.
// Signed operands are handled by multiplying raw bit patterns unsigned and
// subtracting the MSB-weighted correction terms from the upper half of the product.
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  output logic [1:0]        out_mode,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PW     = 2 * DATA_W;

  // ---------------- S1: partials and corrections ----------------
  logic [1:0][HALF_W-1:0] w_a_h, w_b_h;
  logic [3:0][DATA_W-1:0] w_pp;   // 0:ll 1:lh 2:hl 3:hh
  sgn_t                   w_sgn;

  assign w_a_h = src1;
  assign w_b_h = src2;
  assign w_sgn = mode_sign(mode_e'(in_mode));

  for (genvar k = 0; k < 4; k++) begin : g_pp
    cpu_mult_partial #(.HALF_W(HALF_W)) u_pp (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .i_a     (w_a_h[k/2]),
      .i_b     (w_b_h[k%2]),
      .o_p     (w_pp[k])
    );
  end

  logic [DATA_W-1:0] r_corr_a, r_corr_b;
  mode_e             r_mode1;

  // S1 side-band: correction terms and mode travel with the partials.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_corr_a <= '0;
      r_corr_b <= '0;
      r_mode1  <= MODE_MUL;
    end else if (en) begin
      r_corr_a <= (w_sgn.s1 && src1[DATA_W-1]) ? src2 : '0;
      r_corr_b <= (w_sgn.s2 && src2[DATA_W-1]) ? src1 : '0;
      r_mode1  <= mode_e'(in_mode);
    end
  end

  // ---------------- S2: full-width sum ----------------
  logic [DATA_W:0] w_corr;
  logic [PW-1:0]   w_sum;

  // Recombine partials and remove the signed-operand corrections (mod 2^PW).
  always_comb begin
    w_corr = {1'b0, r_corr_a} + {1'b0, r_corr_b};
    w_sum  = PW'(w_pp[0])
           + (PW'(w_pp[1]) << HALF_W)
           + (PW'(w_pp[2]) << HALF_W)
           + (PW'(w_pp[3]) << DATA_W)
           - (PW'(w_corr)  << DATA_W);
  end

  logic [PW-1:0] r_sum;
  mode_e         r_mode2;

  // S2 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum   <= '0;
      r_mode2 <= MODE_MUL;
    end else if (en) begin
      r_sum   <= w_sum;
      r_mode2 <= r_mode1;
    end
  end

  // ---------------- S3: word select ----------------
  logic [DATA_W-1:0] r_res;
  mode_e             r_mode3;

  // S3 register: low word for MUL, high word for the MULX forms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res   <= '0;
      r_mode3 <= MODE_MUL;
    end else if (en) begin
      r_res   <= (r_mode2 == MODE_MUL) ? r_sum[DATA_W-1:0] : r_sum[PW-1:DATA_W];
      r_mode3 <= r_mode2;
    end
  end

  // ---------------- valid pipeline ----------------
  logic [STAGES:1] r_vld;

  // Valids shift with en; flush clears every stage even while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_vld <= '0;
    else if (flush)  r_vld <= '0;
    else if (en)     r_vld <= {r_vld[STAGES-1:1], in_valid};
  end

  assign out_valid = r_vld[STAGES];
  assign out_mode  = r_mode3;
  assign result    = r_res;
  assign busy      = |r_vld;

endmodule

// File: tb/tb_cpu_mult_pipe.sv
// Scoreboard bench: a 32-bit instance for directed cases, a 16-bit instance for random traffic.
module tb_cpu_mult_pipe;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        en32, fl32, iv32;
  logic [1:0]  im32, om32;
  logic [31:0] a32, b32, res32;
  logic        ov32, bz32;

  // 16-bit instance
  logic        en16, fl16, iv16;
  logic [1:0]  im16, om16;
  logic [15:0] a16, b16, res16;
  logic        ov16, bz16;

  cpu_mult_pipe #(.DATA_W(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .en(en32), .flush(fl32), .in_valid(iv32),
    .in_mode(im32), .src1(a32), .src2(b32), .out_valid(ov32), .out_mode(om32),
    .result(res32), .busy(bz32));

  cpu_mult_pipe #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .en(en16), .flush(fl16), .in_valid(iv16),
    .in_mode(im16), .src1(a16), .src2(b16), .out_valid(ov16), .out_mode(om16),
    .result(res16), .busy(bz16));

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits, multiply, pick the word.
  function automatic logic [31:0] ref_mul(input int w, input logic [1:0] m,
                                          input logic [31:0] a, input logic [31:0] b);
    longint     ea, eb;
    logic [63:0] p, mask;
    mask = (64'd1 << w) - 64'd1;
    ea = longint'(a & mask[31:0]);
    eb = longint'(b & mask[31:0]);
    if ((m == 2'd2 || m == 2'd3) && a[w-1]) ea = ea - (longint'(1) << w);
    if ((m == 2'd3) && b[w-1])              eb = eb - (longint'(1) << w);
    p = 64'(ea * eb);
    return (m == 2'd0) ? 32'(p & mask) : 32'((p >> w) & mask);
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [1:0]  mode;
    int          age;   // enabled edges still needed before it reaches the output
  } exp_t;
  exp_t q[$];

  // One clock: drive, advance the expected-timing queue, then check outputs.
  task automatic step(input bit sel, input bit e, input bit f, input bit v,
                      input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] xr);
    logic        ov, bz;
    logic [1:0]  om;
    logic [31:0] rs;
    bit          xv;
    en32 = 1'b0; fl32 = 1'b0; iv32 = 1'b0;
    en16 = 1'b0; fl16 = 1'b0; iv16 = 1'b0;
    if (sel) begin
      en16 = e; fl16 = f; iv16 = v; im16 = m; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      en32 = e; fl32 = f; iv32 = v; im32 = m; a32 = a; b32 = b;
    end
    @(posedge clk);
    if (f) q.delete();
    else if (e) begin
      if (q.size() > 0 && q[0].age == 0) void'(q.pop_front());
      foreach (q[i]) q[i].age--;
      if (v) q.push_back('{xr, m, 2});
    end
    @(negedge clk);
    ov = sel ? ov16 : ov32;
    bz = sel ? bz16 : bz32;
    om = sel ? om16 : om32;
    rs = sel ? {16'h0, res16} : res32;
    xv = (q.size() > 0) && (q[0].age == 0);
    chk("out_valid", {31'b0, ov}, {31'b0, xv});
    chk("busy", {31'b0, bz}, {31'b0, q.size() != 0});
    if (xv) begin
      chk("result", rs, q[0].res);
      chk("out_mode", {30'b0, om}, {30'b0, q[0].mode});
    end
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) step(sel, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
  endtask

  logic [31:0] t1_exp [4];
  logic [1:0]  t2_mode[4];
  logic [31:0] t2_exp [4];

  initial begin
    t1_exp  = '{32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
    t2_mode = '{2'd1, 2'd3, 2'd2, 2'd0};
    t2_exp  = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'h00000000};

    en32 = 0; fl32 = 0; iv32 = 0; im32 = 0; a32 = 0; b32 = 0;
    en16 = 0; fl16 = 0; iv16 = 0; im16 = 0; a16 = 0; b16 = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ov32",  {31'b0, ov32}, 32'h0);
    chk("rst_bz32",  {31'b0, bz32}, 32'h0);
    chk("rst_res32", res32, 32'h0);
    chk("rst_om32",  {30'b0, om32}, 32'h0);
    chk("rst_ov16",  {31'b0, ov16}, 32'h0);
    chk("rst_res16", {16'h0, res16}, 32'h0);
    reset_n = 1'b1;

    // All-ones operands in every mode, back to back.
    for (int m = 0; m < 4; m++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'(m), 32'hFFFFFFFF, 32'hFFFFFFFF, t1_exp[m]);
    idle(1'b0, 4);

    // Most-negative operands.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, t2_mode[i], 32'h80000000, 32'h80000000, t2_exp[i]);
    idle(1'b0, 4);

    // Stall: issue, hold en=0 for five cycles, then resume.
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00001234, 32'h00005678, 32'h06260060);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    idle(1'b0, 3);

    // Flush during a stall with three in flight, then a fresh operation.
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, a, b, ref_mul(32, 2'd3, a, b));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    idle(1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 32'hFFFFFFF9, 32'h00000013,
         ref_mul(32, 2'd2, 32'hFFFFFFF9, 32'h00000013));
    idle(1'b0, 4);

    // Asynchronous reset between edges with work in flight.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'hDEADBEEF, 32'h12345678,
           ref_mul(32, 2'd1, 32'hDEADBEEF, 32'h12345678));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ov",  {31'b0, ov32}, 32'h0);
    chk("arst_res", res32, 32'h0);
    chk("arst_bz",  {31'b0, bz32}, 32'h0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b0, 3);
    chk("post_rst_res", res32, 32'h0);

    // Random traffic on the 16-bit instance.
    for (int i = 0; i < 5000; i++) begin
      bit          e, f, v;
      logic [1:0]  m;
      logic [31:0] a, b;
      e = ($urandom_range(0, 9) < 8);
      f = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000;
        1:       a = 32'hFFFF;
        2:       a = 32'h7FFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? 32'h8000 : $urandom;
      step(1'b1, e, f, v, m, a, b, ref_mul(16, m, a, b));
    end
    idle(1'b1, 4);
    chk("drain_empty", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mult_pipe.md
# cpu_mult_pipe

Parametrised, fully pipelined integer multiplier for the Nios II-class CPU execute/memory path. It supersedes the fixed three-partial-product 16×16 cell, which produced only low-word material. This block forms the full 2·DATA_W product with per-operation signedness and returns either the low or the high word. It adds a valid/flush pipeline so the CPU can stall it with the stage enable and cancel in-flight operations on exceptions.

## Interface
Parameters:
- DATA_W, 32, operand/result width; even, ≥ 8
- HALF_W, DATA_W/2, partial-product operand width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- en  in  1  pipeline advance enable (CPU stage enable); 0 = every stage holds
- flush  in  1  cancel all in-flight operations
- in_valid  in  1  operation present on inputs; sampled when en=1
- in_mode  in  2  0 MUL (low word), 1 MULXUU, 2 MULXSU (src1 signed, src2 unsigned), 3 MULXSS (high words)
- src1  in  DATA_W  multiplicand
- src2  in  DATA_W  multiplier
- out_valid  out  1  result valid
- out_mode  out  2  mode of the operation in result
- result  out  DATA_W  selected product word
- busy  out  1  any stage holds a valid operation

## Operation
- The full product P (2·DATA_W bits) is ext1(src1)·ext2(src2).
  - ext1 sign-extends for modes 2 and 3; otherwise zero-extends.
  - ext2 sign-extends for mode 3 only.
- result is P[DATA_W-1:0] for mode 0 and P[2·DATA_W-1:DATA_W] otherwise.
- Stage 1 (S1): registers four unsigned HALF_W×HALF_W partials (ll, lh, hl, hh). It also registers the mode, valid, and correction terms:
  - corrA = src2 when src1 is treated as signed and src1[MSB]=1, else 0
  - corrB = src1 when src2 is treated as signed and src2[MSB]=1, else 0
- Stage 2 (S2): registers the 2·DATA_W sum ll + (lh<<HALF_W) + (hl<<HALF_W) + (hh<<DATA_W) − ((corrA+corrB)<<DATA_W), taken modulo 2^(2·DATA_W).
- Stage 3 (S3): registers the selected word into result, plus mode and valid.
- en=0: all data and valid registers hold.
- flush=1: clears valid in S1–S3 on that edge, regardless of en. An operation presented with in_valid=1 in the same cycle as flush is also dropped. Data registers need not be cleared.
- Invalid slots still propagate data. result is only meaningful when out_valid=1.

## Timing
- Latency is 3 enabled cycles. An operation accepted on edge k (en=1, in_valid=1, flush=0) appears with out_valid=1 after the third en=1 edge, counting k as the first.
- Throughput is one operation per enabled cycle; no back-pressure beyond en.
- Reset values: out_valid=0, out_mode=0, result=0, busy=0, all internal valids 0, all data registers 0.
- Reset is honoured mid-operation; in-flight operations are lost.
- busy is the OR of the S1, S2 and S3 valids (registered-state derived, no input path).
- Simultaneous flush and en=0: flush wins and valids clear.
- Simultaneous reset and anything else: reset wins.

## Structure
- Package cpu_mult_pkg holds:
  - mode encodings MODE_MUL, MODE_MULXUU, MODE_MULXSU, MODE_MULXSS
  - a helper function returning the signedness pair for a mode
- Sub-module cpu_mult_partial holds one registered unsigned HALF_W×HALF_W multiply, with en and async reset; it is instantiated four times in S1. It maps to a dedicated DSP multiplier.
- The top level owns the correction, the sum, word select, and valid/flush control.

## Test plan
1. DATA_W=32, src1=src2=0xFFFFFFFF in each mode on consecutive cycles. Expected results three cycles later, back-to-back: mode0 0x00000001, mode1 0xFFFFFFFE, mode2 0xFFFFFFFF, mode3 0x00000000.
2. src1=src2=0x80000000. Expected: mode1 0x40000000, mode3 0x40000000, mode2 0xC0000000, mode0 0x00000000.
3. Issue 0x00001234×0x00005678 in mode 0, then hold en=0 for 5 cycles after the first edge. Expected: result 0x06260060 appears only after the 3rd enabled edge, and busy stays 1 throughout the stall.
4. Three valid operations in flight, then flush=1 with en=0 for one cycle. Expected: out_valid never asserts for them, busy=0 on the next cycle, and a new operation issued afterwards completes normally.
5. Assert reset_n=0 asynchronously between edges with operations in flight. Expected: out_valid, result and busy go to 0 immediately without a clock, and stay 0 until new operations are accepted.
6. DATA_W=16, 5000 random operands and modes with random en/flush. Expected: a scoreboard matches every out_valid result to a reference 32-bit extended product in issue order, with no extra or missing outputs.
